// File: rtl/pingpong_frame_buffer_if.sv
// pingpong_frame_buffer_if: bundles the bank selects, byte-stream write port,
// pixel read port and status flags of the ping-pong frame store.
// master = mode FSM / loader / pixel fetch side, slave = frame buffer.
//
// Ports (signals):
//   read_bank1/2, write_bank1/2 : bank selects from the mode FSM
//   in_data/in_valid/in_ready   : packed-pixel byte stream (bit 7 = lowest pixel)
//   rd_en/rd_addr               : pixel read request and pixel index
//   rd_pixel/rd_valid           : pixel result, two cycles after rd_en
//   bank_full/frame_done        : write bank complete level / one-cycle pulse
//   err_conflict                : sticky read/write select collision
interface pingpong_frame_buffer_if #(
  parameter int FRAME_PIXELS = 1280
);
  localparam int PIX_AW = $clog2(FRAME_PIXELS);

  logic              read_bank1;
  logic              read_bank2;
  logic              write_bank1;
  logic              write_bank2;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              rd_en;
  logic [PIX_AW-1:0] rd_addr;
  logic              rd_pixel;
  logic              rd_valid;
  logic              bank_full;
  logic              frame_done;
  logic              err_conflict;

  modport master (
    output read_bank1, read_bank2, write_bank1, write_bank2,
    output in_data, in_valid, rd_en, rd_addr,
    input  in_ready, rd_pixel, rd_valid, bank_full, frame_done, err_conflict
  );

  modport slave (
    input  read_bank1, read_bank2, write_bank1, write_bank2,
    input  in_data, in_valid, rd_en, rd_addr,
    output in_ready, rd_pixel, rd_valid, bank_full, frame_done, err_conflict
  );
endinterface

// File: rtl/pingpong_frame_buffer.sv
// Purpose: double-buffered 1bpp frame store between the byte loader and VGA pixel fetch.
// Latency: byte written on the accepting edge; pixel read returns 2 cycles after rd_en.
// Backpressure: in_ready is low on a bank swap, once the bank is full, on a
//               select conflict, and in IDLE; it never depends on in_valid.
//
// Ports:
//   CLK_40 : 40 MHz system clock
//   reset  : synchronous, active-high
//   bus    : pingpong_frame_buffer_if slave (selects, byte stream, pixel read, status)
// The interface instance must be built with the same FRAME_PIXELS as this module.
module pingpong_frame_buffer #(
  parameter int FRAME_PIXELS = 1280
) (
  input  logic                    CLK_40,
  input  logic                    reset,
  pingpong_frame_buffer_if.slave  bus
);

  localparam int BYTES   = FRAME_PIXELS / 8;
  localparam int PIX_AW  = $clog2(FRAME_PIXELS);
  localparam int BYTE_AW = $clog2(BYTES);

  localparam logic [BYTE_AW-1:0] LAST_BYTE = BYTE_AW'(BYTES - 1);
  localparam logic [PIX_AW:0]    PIX_LIMIT = (PIX_AW + 1)'(FRAME_PIXELS);

  // Bank storage; deliberately not cleared by reset.
  logic [7:0] bank1_mem [BYTES];
  logic [7:0] bank2_mem [BYTES];

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  logic               wr_active;
  logic               wr_swap;
  logic               wr_accept;
  logic               in_ready_c;

  logic [BYTE_AW-1:0] wr_ptr_q,     wr_ptr_d;
  logic               wsel_q,       wsel_d;
  logic               bank_full_q,  bank_full_d;
  logic               frame_done_q, frame_done_d;
  logic               err_q,        err_d;

  assign wr_active = bus.write_bank1 ^ bus.write_bank2;
  // wsel_q remembers which bank the pointer belongs to; any change of the
  // active write bank restarts the frame.
  assign wr_swap   = wr_active & (bus.write_bank2 != wsel_q);

  // reset is included so nothing is offered while the block is being reset.
  assign in_ready_c = wr_active & ~wr_swap & ~bank_full_q & ~err_q & ~reset;
  assign wr_accept  = bus.in_valid & in_ready_c;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    wsel_d       = wsel_q;
    bank_full_d  = bank_full_q;
    frame_done_d = 1'b0;
    err_d        = err_q
                 | (bus.read_bank1 & bus.write_bank1)
                 | (bus.read_bank2 & bus.write_bank2);

    if (wr_swap) begin
      wr_ptr_d    = '0;
      bank_full_d = 1'b0;
      wsel_d      = bus.write_bank2;
    end else if (wr_accept) begin
      if (wr_ptr_q == LAST_BYTE) begin
        // Pointer parks on the last byte; in_ready stays low until a swap.
        bank_full_d  = 1'b1;
        frame_done_d = 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q + BYTE_AW'(1);
      end
    end
  end

  always_ff @(posedge CLK_40) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      wsel_q       <= 1'b0;
      bank_full_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      wsel_q       <= wsel_d;
      bank_full_q  <= bank_full_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage access. The read of stage 1 and the write share this block, so a
  // same-address read in the write cycle sees the old byte.
  // ---------------------------------------------------------------------------
  logic [BYTE_AW-1:0] rd_byte_idx;
  logic               rd_inrange;
  logic [7:0]         s1_byte_q;

  assign rd_byte_idx = bus.rd_addr[PIX_AW-1:3];
  assign rd_inrange  = ({1'b0, bus.rd_addr} < PIX_LIMIT);

  always_ff @(posedge CLK_40) begin
    if (wr_accept) begin
      // wr_accept excludes the swap cycle, so write_bank2 equals wsel_q here.
      if (bus.write_bank2) begin
        bank2_mem[wr_ptr_q] <= bus.in_data;
      end else begin
        bank1_mem[wr_ptr_q] <= bus.in_data;
      end
    end
    // Out-of-range indices never touch the arrays; the pixel is forced to 0.
    if (bus.rd_en && rd_inrange) begin
      s1_byte_q <= bus.read_bank2 ? bank2_mem[rd_byte_idx] : bank1_mem[rd_byte_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline control
  // ---------------------------------------------------------------------------
  logic       s1_vld_q;
  logic [2:0] s1_bit_q;
  logic       s1_inrange_q;
  logic       s1_sel_ok_q;
  logic       rd_pixel_q, rd_pixel_d;
  logic       rd_valid_q;

  // Pixel index 0 lives in bit 7, so byte bit = 7 - bit_idx = ~bit_idx.
  always_comb begin
    rd_pixel_d = 1'b0;
    if (s1_inrange_q && s1_sel_ok_q) begin
      rd_pixel_d = s1_byte_q[~s1_bit_q];
    end
  end

  always_ff @(posedge CLK_40) begin
    if (reset) begin
      s1_vld_q     <= 1'b0;
      s1_bit_q     <= 3'd0;
      s1_inrange_q <= 1'b0;
      s1_sel_ok_q  <= 1'b0;
      rd_pixel_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      s1_vld_q   <= bus.rd_en;
      rd_valid_q <= s1_vld_q;
      if (bus.rd_en) begin
        s1_bit_q     <= bus.rd_addr[2:0];
        s1_inrange_q <= rd_inrange;
        s1_sel_ok_q  <= bus.read_bank1 ^ bus.read_bank2;
      end
      if (s1_vld_q) begin
        rd_pixel_q <= rd_pixel_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.in_ready     = in_ready_c;
  assign bus.rd_pixel     = rd_pixel_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.bank_full    = bank_full_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.err_conflict = err_q;

endmodule

// File: tb/tb_pingpong_frame_buffer.sv
`timescale 1ns/1ps
module tb_pingpong_frame_buffer;

  localparam int FP = 1280;
  localparam int NB = 160;

  logic CLK_40 = 1'b0;
  logic reset  = 1'b1;
  always #5 CLK_40 = ~CLK_40;

  pingpong_frame_buffer_if #(.FRAME_PIXELS(FP)) bus_if ();

  pingpong_frame_buffer #(.FRAME_PIXELS(FP)) dut (
    .CLK_40 (CLK_40),
    .reset  (reset),
    .bus    (bus_if.slave)
  );

  typedef struct {
    logic        rb1;
    logic        rb2;
    logic [10:0] addr;
    logic        exp;
  } rd_vec_t;

  rd_vec_t    tbl [14];
  rd_vec_t    rq [$];
  logic [7:0] model [2][NB];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic next();
    @(posedge CLK_40);
    #1;
  endtask

  function automatic logic mbit(input int bank, input int a);
    logic [7:0] b;
    b = model[bank][a / 8];
    return b[7 - (a % 8)];
  endfunction

  task automatic push_model(input int bank, input int first, input int last);
    rd_vec_t v;
    for (int a = first; a <= last; a++) begin
      v.rb1  = (bank == 0);
      v.rb2  = (bank == 1);
      v.addr = 11'(a);
      v.exp  = mbit(bank, a);
      rq.push_back(v);
    end
  endtask

  // Issue every queued read back-to-back; result j appears 2 cycles later.
  task automatic run_reads(input string tag);
    int n;
    n = rq.size();
    for (int j = 0; j < n + 2; j++) begin
      if (j >= 2) begin
        chk($sformatf("%s rd_valid[%0d]", tag, j - 2), 32'(bus_if.rd_valid), 32'd1);
        chk($sformatf("%s rd_pixel[addr %0d]", tag, rq[j-2].addr), 32'(bus_if.rd_pixel),
            32'(rq[j-2].exp));
      end else begin
        chk($sformatf("%s rd_valid latency %0d", tag, j), 32'(bus_if.rd_valid), 32'd0);
      end
      if (j < n) begin
        bus_if.read_bank1 = rq[j].rb1;
        bus_if.read_bank2 = rq[j].rb2;
        bus_if.rd_addr    = rq[j].addr;
        bus_if.rd_en      = 1'b1;
      end else begin
        bus_if.rd_en = 1'b0;
      end
      next();
    end
    rq.delete();
  endtask

  // Offer nbytes to the current write bank; records accepted bytes in the model.
  task automatic stream(input int bank, input bit rnd, input logic [7:0] base,
                        input int nbytes, output int acc, output int cyc);
    logic [7:0] cur;
    acc = 0;
    cyc = 0;
    cur = rnd ? 8'($urandom) : base;
    while (acc < nbytes && cyc < 4000) begin
      bus_if.in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus_if.in_data  = cur;
      #1;
      if (bus_if.in_valid && bus_if.in_ready) begin
        model[bank][acc] = cur;
        acc++;
        cur = rnd ? 8'($urandom) : base + 8'(acc);
      end
      @(posedge CLK_40);
      #1;
      cyc++;
    end
    bus_if.in_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " in_ready"},     32'(bus_if.in_ready),     32'd0);
    chk({tag, " rd_pixel"},     32'(bus_if.rd_pixel),     32'd0);
    chk({tag, " rd_valid"},     32'(bus_if.rd_valid),     32'd0);
    chk({tag, " bank_full"},    32'(bus_if.bank_full),    32'd0);
    chk({tag, " frame_done"},   32'(bus_if.frame_done),   32'd0);
    chk({tag, " err_conflict"}, 32'(bus_if.err_conflict), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    int acc, cyc;
    rd_vec_t v;

    // Bank2 holds bytes 0x00..0x9F when the table is applied.
    tbl[0]  = '{1'b0, 1'b1, 11'd15,   1'b1};  // byte 0x01, last pixel
    tbl[1]  = '{1'b0, 1'b1, 11'd14,   1'b0};
    tbl[2]  = '{1'b0, 1'b1, 11'd1279, 1'b1};  // bit 0 of byte 0x9F
    tbl[3]  = '{1'b0, 1'b1, 11'd1280, 1'b0};  // first out-of-range index
    tbl[4]  = '{1'b0, 1'b1, 11'd1272, 1'b1};  // bit 7 of 0x9F
    tbl[5]  = '{1'b0, 1'b1, 11'd1273, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 11'd1274, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 11'd1275, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 11'd680,  1'b0};  // byte 0x55
    tbl[9]  = '{1'b0, 1'b1, 11'd681,  1'b1};
    tbl[10] = '{1'b0, 1'b1, 11'd1024, 1'b1};  // byte 0x80
    tbl[11] = '{1'b0, 1'b1, 11'd1025, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 11'd15,   1'b0};  // no read bank selected
    tbl[13] = '{1'b0, 1'b1, 11'd2047, 1'b0};  // far out of range

    bus_if.read_bank1  = 1'b0;
    bus_if.read_bank2  = 1'b0;
    bus_if.write_bank1 = 1'b0;
    bus_if.write_bank2 = 1'b0;
    bus_if.in_data     = 8'h00;
    bus_if.in_valid    = 1'b0;
    bus_if.rd_en       = 1'b0;
    bus_if.rd_addr     = '0;

    // Reset state
    reset = 1'b1;
    next();
    next();
    chk_all_zero("reset");
    reset = 1'b0;

    // Fill bank2 without stalls; the first cycle is the swap cycle.
    bus_if.write_bank2 = 1'b1;
    bus_if.read_bank1  = 1'b1;
    bus_if.in_valid    = 1'b1;
    bus_if.in_data     = 8'h00;
    #1;
    chk("swap cycle in_ready", 32'(bus_if.in_ready), 32'd0);
    next();
    stream(1, 1'b0, 8'h00, NB, acc, cyc);
    chk("fill handshakes", 32'(acc), 32'(NB));
    chk("fill cycles", 32'(cyc), 32'(NB));
    chk("fill bank_full", 32'(bus_if.bank_full), 32'd1);
    chk("fill frame_done", 32'(bus_if.frame_done), 32'd1);
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 8'hEE;
    #1;
    chk("full in_ready a", 32'(bus_if.in_ready), 32'd0);
    next();
    chk("frame_done pulse end", 32'(bus_if.frame_done), 32'd0);
    chk("full bank_full hold", 32'(bus_if.bank_full), 32'd1);
    chk("full in_ready b", 32'(bus_if.in_ready), 32'd0);
    next();
    chk("full in_ready c", 32'(bus_if.in_ready), 32'd0);
    bus_if.in_valid = 1'b0;

    // Swap: read bank2, write bank1.
    bus_if.write_bank2 = 1'b0;
    bus_if.write_bank1 = 1'b1;
    bus_if.read_bank1  = 1'b0;
    bus_if.read_bank2  = 1'b1;
    #1;
    chk("swap2 in_ready", 32'(bus_if.in_ready), 32'd0);
    next();
    chk("swap2 bank_full", 32'(bus_if.bank_full), 32'd0);
    for (int a = 0; a < 16; a++) begin
      v = '{1'b0, 1'b1, 11'(a), (a == 15)};
      rq.push_back(v);
    end
    run_reads("rd0_15");
    for (int i = 0; i < 14; i++) rq.push_back(tbl[i]);
    run_reads("tbl");
    bus_if.read_bank1 = 1'b0;
    bus_if.read_bank2 = 1'b1;

    // Random backpressure into bank1, then full readback.
    stream(0, 1'b1, 8'h00, NB, acc, cyc);
    chk("rnd accepted", 32'(acc), 32'(NB));
    chk("rnd bank_full", 32'(bus_if.bank_full), 32'd1);
    bus_if.write_bank1 = 1'b0;
    bus_if.write_bank2 = 1'b1;
    bus_if.read_bank2  = 1'b0;
    bus_if.read_bank1  = 1'b1;
    next();
    push_model(0, 0, FP - 1);
    run_reads("full");

    // Mid-frame swap after 50 bytes into bank2, in_valid held through the swap.
    stream(1, 1'b0, 8'hA0, 50, acc, cyc);
    chk("mid accepted", 32'(acc), 32'd50);
    chk("mid bank_full", 32'(bus_if.bank_full), 32'd0);
    bus_if.write_bank2 = 1'b0;
    bus_if.write_bank1 = 1'b1;
    bus_if.read_bank1  = 1'b0;
    bus_if.read_bank2  = 1'b1;
    bus_if.in_valid    = 1'b1;
    bus_if.in_data     = 8'h5A;
    #1;
    chk("mid swap in_ready", 32'(bus_if.in_ready), 32'd0);
    next();
    chk("mid swap bank_full", 32'(bus_if.bank_full), 32'd0);
    chk("mid post-swap in_ready", 32'(bus_if.in_ready), 32'd1);
    next();
    model[0][0] = 8'h5A;
    bus_if.in_valid    = 1'b0;
    bus_if.write_bank1 = 1'b0;
    bus_if.write_bank2 = 1'b1;
    bus_if.read_bank2  = 1'b0;
    bus_if.read_bank1  = 1'b1;
    next();
    push_model(0, 0, 15);
    push_model(0, 400, 407);
    run_reads("midswap");

    // Reset after 90 bytes of a bank2 frame.
    stream(1, 1'b0, 8'h30, 90, acc, cyc);
    chk("pre-reset accepted", 32'(acc), 32'd90);
    reset           = 1'b1;
    bus_if.rd_en    = 1'b1;
    bus_if.rd_addr  = '0;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 8'hFF;
    next();
    chk_all_zero("midreset");
    reset           = 1'b0;
    bus_if.rd_en    = 1'b0;
    bus_if.in_valid = 1'b0;
    stream(1, 1'b0, 8'hC3, 1, acc, cyc);
    chk("post-reset accepted", 32'(acc), 32'd1);
    bus_if.write_bank2 = 1'b0;
    bus_if.write_bank1 = 1'b1;
    bus_if.read_bank1  = 1'b0;
    bus_if.read_bank2  = 1'b1;
    next();
    push_model(1, 0, 15);
    push_model(1, 720, 727);
    run_reads("rst_discard");

    // Conflict: read and write both on bank1.
    bus_if.read_bank1 = 1'b1;
    bus_if.read_bank2 = 1'b0;
    next();
    chk("conflict set", 32'(bus_if.err_conflict), 32'd1);
    bus_if.read_bank1 = 1'b0;
    bus_if.read_bank2 = 1'b1;
    bus_if.in_valid   = 1'b1;
    bus_if.in_data    = 8'h77;
    #1;
    chk("conflict in_ready", 32'(bus_if.in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      next();
      chk($sformatf("conflict sticky %0d", k), 32'(bus_if.err_conflict), 32'd1);
      chk($sformatf("conflict blocked %0d", k), 32'(bus_if.in_ready), 32'd0);
    end
    bus_if.in_valid = 1'b0;
    rq.push_back('{1'b0, 1'b1, 11'd0, 1'b1});   // 0xC3 = 1100_0011
    rq.push_back('{1'b0, 1'b1, 11'd2, 1'b0});
    rq.push_back('{1'b0, 1'b1, 11'd7, 1'b1});
    run_reads("conflict_rd");
    reset = 1'b1;
    next();
    reset = 1'b0;
    chk("conflict cleared by reset", 32'(bus_if.err_conflict), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pingpong_frame_buffer.md
# pingpong_frame_buffer

- Double-buffered 1-bit-per-pixel frame store between the byte-stream frame loader (upstream) and the VGA pixel fetch (downstream).
- Packed frame bytes are written into whichever bank the mode FSM marks as the write bank. Pixels are read by index from the read bank.
- Reports when the write bank holds a complete frame, so the mode FSM can swap banks.

## Interface

Parameters:
- FRAME_PIXELS, default 1280 (40x32): pixels per frame. Must be a multiple of 8.
- BYTES: derived, FRAME_PIXELS/8 (160 by default). Bytes per bank.
- PIX_AW: derived, $clog2(FRAME_PIXELS) (11 by default).
- BYTE_AW: derived, $clog2(BYTES) (8 by default).

Ports (reset is synchronous, active-high; clock is CLK_40):
- CLK_40  in  1  system clock, 40 MHz.
- reset  in  1  synchronous, active-high.
- read_bank1, read_bank2  in  1 each  read-bank select from the mode FSM.
- write_bank1, write_bank2  in  1 each  write-bank select from the mode FSM.
- in_data  in  8  packed pixels; bit 7 is the lowest pixel index.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  byte is accepted on a cycle where in_valid and in_ready are both high.
- rd_en  in  1  pixel read request.
- rd_addr  in  PIX_AW  pixel index, 0..FRAME_PIXELS-1.
- rd_pixel  out  1  pixel value.
- rd_valid  out  1  rd_pixel is valid.
- bank_full  out  1  the current write bank holds BYTES accepted bytes.
- frame_done  out  1  one-cycle pulse when bank_full rises.
- err_conflict  out  1  sticky; set when read and write select the same bank.

## Operation

Storage:
- Two byte-wide arrays, bank1 and bank2, each of depth BYTES.
- Contents are not cleared by reset.

Write side:
- active = write_bank1 XOR write_bank2.
- The write target is bank2 when write_bank2 = 1, otherwise bank1.
- wsel_q is a register holding write_bank2.
- swap = active AND (write_bank2 != wsel_q).
- On swap: wr_ptr <= 0, bank_full <= 0, wsel_q <= write_bank2. in_ready is low during the swap cycle.
- in_ready = active AND NOT swap AND NOT bank_full AND NOT err_conflict. It depends only on registered state and the select inputs, never on in_valid.
- On each accepted byte: write in_data to target[wr_ptr], then wr_ptr <= wr_ptr + 1.
- When the byte at wr_ptr = BYTES-1 is accepted: bank_full <= 1 and frame_done <= 1 on the next cycle, and wr_ptr holds at BYTES-1.
- While bank_full is 1, in_ready stays 0 until the next swap.

Read side (two-stage pipeline):
- Stage 1, on a cycle with rd_en:
  - Register the byte at rd_addr[PIX_AW-1:3] from the read bank (bank2 when read_bank2 = 1, else bank1).
  - Register bit_idx = rd_addr[2:0].
  - Register an inrange flag = (rd_addr < FRAME_PIXELS).
  - Register rsel_ok = read_bank1 XOR read_bank2.
- Stage 2: rd_pixel <= byte[7 - bit_idx] when inrange AND rsel_ok, else 0.
- rd_valid is rd_en delayed by 2 cycles.

Conflict:
- err_conflict is set when (read_bank1 AND write_bank1) OR (read_bank2 AND write_bank2).
- Once set, it is cleared only by reset.
- While err_conflict is set, writes are blocked; reads continue.

## Timing

- Reset values: in_ready 0, rd_pixel 0, rd_valid 0, bank_full 0, frame_done 0, err_conflict 0. Internally wr_ptr 0 and wsel_q 0.
- Reset mid-frame discards the partial frame. The next accepted byte goes to address 0.
- Read latency: 2 cycles from rd_en to rd_valid/rd_pixel. Back-to-back reads give one pixel per cycle.
- A read and a write to the same bank and address in the same cycle return the old data (read-before-write).
- A bank swap that coincides with in_valid: that byte is not accepted, and the source must hold it.
- frame_done is high for exactly 1 cycle per filled bank.
- Selects changing while bank_full is 0 still trigger a swap: the partial frame is abandoned and the pointer returns to 0.
- No select active (IDLE): in_ready is 0 and rd_pixel reads 0.

## Test plan

- Fill without stalls:
  - Stimulus: reset, then write_bank2 = 1 and read_bank1 = 1; stream 160 bytes 0x00..0x9F with in_valid held high.
  - Required: 160 handshakes; bank_full rises the cycle after the last byte; frame_done is a 1-cycle pulse; in_ready stays 0 afterwards.
- Read after swap:
  - Stimulus: swap to read_bank2 / write_bank1; read rd_addr 0..15 back-to-back.
  - Required: rd_valid asserts 2 cycles after rd_en; pixels match the bits of bytes 0x00 and 0x01 MSB-first (pixel 15 = 1, pixels 0..14 = 0).
- Random backpressure:
  - Stimulus: in_valid toggles randomly.
  - Required: exactly 160 bytes are accepted; readback of all 1280 pixels matches a scoreboard.
- Mid-frame swap and reset:
  - Stimulus: swap after 50 bytes.
  - Required: wr_ptr returns to 0, bank_full is 0, and the next byte lands at address 0.
  - Stimulus: assert reset at byte 90.
  - Required: all outputs are 0 on the next cycle.
- Boundaries:
  - Stimulus: rd_addr = 1279.
  - Required: returns bit 0 of byte 159.
  - Stimulus: rd_addr = 1280.
  - Required: rd_pixel = 0.
  - Stimulus: in_valid held through the swap cycle.
  - Required: no acceptance that cycle.
- Conflict:
  - Stimulus: read_bank1 = 1 and write_bank1 = 1 together.
  - Required: err_conflict sets and stays set; in_ready is 0; only reset clears it.
